jk_excite_ctrl: RTL and testbench
=================================

# jk_excite_ctrl

Controller that drives the J/K inputs of a WIDTH-bit bank of JK flip-flops and checks the bank's Q outputs. Each request is taken over a valid/ready handshake and is one of four operations: load a target value, count up, count down, or hold. For every step the block computes the minimal JK excitation, waits one flop update, and compares Q with the expected value. A mismatch is retried a bounded number of times and then latched as a sticky error. The block is the driving end of the JK flip-flop bank: it produces J/K and consumes Q.

## Interface
- WIDTH, 4: number of JK flip-flops in the bank.
- MAX_RETRY, 2: number of re-drives allowed per step after a Q mismatch.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- TGT  in  WIDTH  target value, used only in load mode.
- MODE  in  2  operation: 00 load, 01 count up, 10 count down, 11 hold.
- STEPS  in  8  number of steps for modes 01, 10 and 11; ignored in load mode.
- TGT_VALID  in  1  request valid.
- TGT_READY  out  1  request ready; high only in IDLE, with no error and RST low.
- J  out  WIDTH  registered J drive to the flop bank.
- K  out  WIDTH  registered K drive to the flop bank.
- Q  in  WIDTH  Q outputs of the flop bank.
- BUSY  out  1  high in every state except IDLE and ERR.
- DONE  out  1  one-cycle pulse when a request completes.
- ERR  out  1  sticky error flag; cleared only by RST.
- ERR_BIT  out  WIDTH  Q XOR EXP captured at the failing check.

## Operation
- Request acceptance: a request is accepted on the edge where TGT_VALID and TGT_READY are both high. At that edge TGT, MODE and STEPS are latched, the step count is loaded (forced to 1 in load mode), and the FSM moves to DRIVE.
- Next value d, first attempt of a step:
  - Load: d = TGT.
  - Count up: d = Q+1, modulo 2^WIDTH.
  - Count down: d = Q−1, modulo 2^WIDTH.
  - Hold: d = Q.
- Next value d, retry: d = EXP, the value stored on the first attempt.
- Excitation, per bit: J_i = ~Q_i & d_i and K_i = Q_i & ~d_i. Both are 0 when no change is needed; J=K=1 (toggle) is never driven.
- FSM states:
  - IDLE: J=K=0. Goes to DRIVE on acceptance.
  - DRIVE: registers J, K and EXP=d. Goes to WAIT.
  - WAIT: holds J/K for the flop capture edge. Goes to CHECK and clears J/K to 0 at that edge.
  - CHECK, Q==EXP: clears the retry count and decrements the step count. If the step count was 1, pulses DONE and goes to IDLE; otherwise goes to DRIVE.
  - CHECK, Q!=EXP with retries < MAX_RETRY: increments the retry count and goes to DRIVE.
  - CHECK, Q!=EXP with retries exhausted: sets ERR and ERR_BIT and goes to ERR.
  - ERR: J=K=0 and TGT_READY=0. The FSM stays here until RST.
- STEPS=0 in a counting or hold mode: no drive. DONE pulses on the edge after acceptance and the FSM returns to IDLE.
- Load with TGT equal to Q: still a full step with J=K=0; the check must pass.
- Wrap-around: count up from all ones gives 0; count down from 0 gives all ones.

## Timing
- Reset values: J=0, K=0, BUSY=0, DONE=0, ERR=0, ERR_BIT=0, state IDLE. TGT_READY is 0 while RST is high and 1 on the cycle after RST falls.
- Step latency: 3 cycles. For acceptance at edge a: J/K are valid from a+1 to a+2, the flop bank captures at a+2, and the compare happens at a+3.
- Request completion: DONE is high for the single cycle after the final CHECK edge. TGT_READY is high in that same cycle, so back-to-back requests are accepted with no gap.
- Total latency without retries: 3·n cycles from the acceptance edge to the DONE edge, where n is the step count.
- Each retry adds 3 cycles.
- Reset during an operation: on that edge J/K go to 0, the FSM goes to IDLE and all counters clear. No DONE is produced.
- TGT_VALID while not ready: the request is ignored, with no latching.

## Structure
- Package jk_pkg holds:
  - the mode constants MODE_LOAD, MODE_UP, MODE_DOWN and MODE_HOLD;
  - the FSM state encoding for IDLE, DRIVE, WAIT, CHECK and ERR.
- Sub-module jk_excite: purely combinational, parameter WIDTH, inputs q and d, outputs j and k. It implements the excitation equations above.
- Top level: the FSM, the step counter (8 bits), the retry counter (width clog2(MAX_RETRY+1)), and the EXP, J/K and ERR_BIT registers.

## Test plan
- Load: WIDTH=4, bank Q=0101, load TGT=1010 → J=1010 and K=0101 for one cycle, Q=1010 at the check, DONE 3 cycles after acceptance, ERR=0.
- Count-up wrap: Q=1110, STEPS=3, count up → Q goes 1111, 0000, 0001; DONE at cycle 9; ERR=0.
- Stuck bit: Q bit 2 stuck at 0, count up from 0011 → 1 initial attempt plus 2 retries, then ERR=1, ERR_BIT=0100, TGT_READY=0; J=K=0 afterwards.
- Reset mid-operation: RST asserted in WAIT during a count-down → J=K=0 and BUSY=0 on the next edge, no DONE, TGT_READY=1 after RST falls.
- Zero steps and back-to-back: a count-up request with STEPS=0 → DONE on the edge after acceptance. A second request presented with TGT_VALID held high is accepted in the DONE cycle.
- Hold: Q=1001, hold with STEPS=2 → J=K=0 throughout, DONE at cycle 6, Q unchanged.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared encodings for the JK flip-flop bank excitation controller.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/jk_excite.sv
// Minimal JK excitation: set bits that must rise, reset bits that must fall, never toggle.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    assign j = ~q & d;
    assign k = q & ~d;

endmodule

// File: rtl/jk_excite_ctrl.sv
// Drives J/K of a JK flop bank step by step, verifies Q after each update and
// retries a bounded number of times before latching a sticky error.
module jk_excite_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] TGT,
    input  logic [1:0]       MODE,
    input  logic [7:0]       STEPS,
    input  logic             TGT_VALID,
    output logic             TGT_READY,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] ERR_BIT
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t           state, state_n;
    logic [7:0]       step_cnt, step_n;
    logic [RW-1:0]    retry_cnt, retry_n;
    logic [WIDTH-1:0] j_q, j_n, k_q, k_n;
    logic [WIDTH-1:0] err_bit_q, err_bit_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    mode_t            mode_q, mode_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ej, ek;

    // Retries re-aim at the value chosen on the first attempt, not at a fresh Q-relative value.
    always_comb begin
        d = Q;
        if (retry_cnt != '0) begin
            d = exp_q;
        end else begin
            case (mode_q)
                MODE_LOAD: d = tgt_q;
                MODE_UP:   d = Q + WIDTH'(1);
                MODE_DOWN: d = Q - WIDTH'(1);
                MODE_HOLD: d = Q;
                default:   d = Q;
            endcase
        end
    end

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q (Q),
        .d (d),
        .j (ej),
        .k (ek)
    );

    assign TGT_READY = (state == S_IDLE) && !err_q && !RST;
    assign BUSY      = (state != S_IDLE) && (state != S_ERR);
    assign J         = j_q;
    assign K         = k_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_BIT   = err_bit_q;

    always_comb begin
        state_n   = state;
        step_n    = step_cnt;
        retry_n   = retry_cnt;
        j_n       = j_q;
        k_n       = k_q;
        done_n    = 1'b0;
        err_n     = err_q;
        err_bit_n = err_bit_q;
        mode_n    = mode_q;
        tgt_n     = tgt_q;
        exp_n     = exp_q;
        case (state)
            S_IDLE: begin
                j_n = '0;
                k_n = '0;
                if (TGT_VALID && TGT_READY) begin
                    mode_n  = mode_t'(MODE);
                    tgt_n   = TGT;
                    step_n  = (mode_t'(MODE) == MODE_LOAD) ? 8'd1 : STEPS;
                    retry_n = '0;
                    state_n = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (step_cnt == 8'd0) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    j_n     = ej;
                    k_n     = ek;
                    exp_n   = d;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                j_n     = '0;
                k_n     = '0;
                state_n = S_CHECK;
            end
            S_CHECK: begin
                if (Q == exp_q) begin
                    retry_n = '0;
                    step_n  = step_cnt - 8'd1;
                    if (step_cnt == 8'd1) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DRIVE;
                    end
                end else if (retry_cnt < RETRY_LIMIT) begin
                    retry_n = retry_cnt + RW'(1);
                    state_n = S_DRIVE;
                end else begin
                    err_n     = 1'b1;
                    err_bit_n = Q ^ exp_q;
                    state_n   = S_ERR;
                end
            end
            S_ERR: begin
                j_n = '0;
                k_n = '0;
            end
            default: begin
                j_n     = '0;
                k_n     = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            step_cnt  <= '0;
            retry_cnt <= '0;
            j_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_bit_q <= '0;
        end else begin
            state     <= state_n;
            step_cnt  <= step_n;
            retry_cnt <= retry_n;
            j_q       <= j_n;
            k_q       <= k_n;
            done_q    <= done_n;
            err_q     <= err_n;
            err_bit_q <= err_bit_n;
        end
    end

    // Request fields and the expected value are pure data and need no reset.
    always_ff @(posedge CLK) begin
        mode_q <= mode_n;
        tgt_q  <= tgt_n;
        exp_q  <= exp_n;
    end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Directed bench for jk_excite_ctrl with a behavioural JK flop bank on J/K/Q.
module tb_jk_excite_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tgt;
    logic [1:0] mode;
    logic [7:0] steps;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] j, k, q_bank;
    logic       busy, done, err;
    logic [3:0] err_bit;

    logic       preset_en = 1'b0;
    logic [3:0] preset_val = 4'h0;
    logic [3:0] stuck = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // JK characteristic Qn = J & ~Q | ~K & Q, with optional stuck-at-0 bits.
    always @(posedge clk) begin
        if (preset_en) q_bank <= preset_val & ~stuck;
        else           q_bank <= ((j & ~q_bank) | (~k & q_bank)) & ~stuck;
    end

    jk_excite_ctrl #(.WIDTH(4), .MAX_RETRY(2)) dut (
        .CLK       (clk),
        .RST       (rst),
        .TGT       (tgt),
        .MODE      (mode),
        .STEPS     (steps),
        .TGT_VALID (tgt_valid),
        .TGT_READY (tgt_ready),
        .J         (j),
        .K         (k),
        .Q         (q_bank),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .ERR_BIT   (err_bit)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic preset(input logic [3:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
    endtask

    task automatic request(input logic [1:0] m, input logic [3:0] t, input logic [7:0] s);
        mode      = m;
        tgt       = t;
        steps     = s;
        tgt_valid = 1'b1;
        chk("ready_before_accept", tgt_ready, 1);
        tick();
        tgt_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tgt = 4'h0; mode = 2'b00; steps = 8'd0; tgt_valid = 1'b0;
        tick();
        tick();
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_bit", err_bit, 0);
        chk("rst_ready_low", tgt_ready, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", tgt_ready, 1);

        // Load 0101 -> 1010
        preset(4'b0101);
        request(2'b00, 4'b1010, 8'd7);
        chk("load_busy", busy, 1);
        chk("load_j_idle", j, 0);
        tick();
        chk("load_j", j, 4'b1010);
        chk("load_k", k, 4'b0101);
        tick();
        chk("load_q", q_bank, 4'b1010);
        chk("load_j_clr", j, 0);
        chk("load_done_early", done, 0);
        tick();
        chk("load_done", done, 1);
        chk("load_err", err, 0);
        chk("load_ready_in_done", tgt_ready, 1);
        tick();
        chk("load_done_pulse", done, 0);
        chk("load_busy_end", busy, 0);

        // Count up 1110, three steps, wrapping through 0000
        preset(4'b1110);
        request(2'b01, 4'h0, 8'd3);
        tick();
        chk("up_j1", j, 4'b0001);
        tick();
        chk("up_q1", q_bank, 4'b1111);
        tick(); tick();
        chk("up_k2", k, 4'b1111);
        tick();
        chk("up_q2_wrap", q_bank, 4'b0000);
        tick(); tick(); tick();
        chk("up_q3", q_bank, 4'b0001);
        chk("up_done_early", done, 0);
        tick();
        chk("up_done_cycle9", done, 1);
        chk("up_err", err, 0);
        tick();

        // Count down wrap 0000 -> 1111, single step
        preset(4'b0000);
        request(2'b10, 4'h0, 8'd1);
        tick(); tick();
        chk("down_wrap_q", q_bank, 4'b1111);
        tick();
        chk("down_done", done, 1);
        tick();

        // Bit 2 stuck at 0, count up from 0011
        stuck = 4'b0100;
        preset(4'b0011);
        request(2'b01, 4'h0, 8'd1);
        tick();
        chk("stuck_j1", j, 4'b0100);
        chk("stuck_k1", k, 4'b0011);
        tick(); tick(); tick();
        chk("stuck_retry_j", j, 4'b0100);
        chk("stuck_retry_k", k, 4'b0000);
        tick(); tick(); tick(); tick();
        chk("stuck_err_early", err, 0);
        chk("stuck_busy", busy, 1);
        tick();
        chk("stuck_err", err, 1);
        chk("stuck_err_bit", err_bit, 4'b0100);
        chk("stuck_ready", tgt_ready, 0);
        chk("stuck_busy_off", busy, 0);
        chk("stuck_done", done, 0);
        tgt_valid = 1'b1; mode = 2'b00; tgt = 4'hF;
        tick();
        tgt_valid = 1'b0;
        chk("err_sticky", err, 1);
        chk("err_j", j, 0);
        chk("err_k", k, 0);
        chk("err_busy_ignored_req", busy, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stuck = 4'h0;
        chk("err_cleared", err, 0);
        chk("err_bit_cleared", err_bit, 0);

        // Reset while in WAIT during a count-down
        preset(4'b0110);
        request(2'b10, 4'h0, 8'd2);
        tick();
        chk("rstop_j_drive", j, 4'b0001);
        rst = 1'b1;
        tick();
        chk("rstop_j", j, 0);
        chk("rstop_k", k, 0);
        chk("rstop_busy", busy, 0);
        chk("rstop_done", done, 0);
        rst = 1'b0;
        tick();
        chk("rstop_ready", tgt_ready, 1);
        chk("rstop_no_done", done, 0);
        tick();
        chk("rstop_idle", busy, 0);

        // Zero steps, then a back-to-back load held valid
        preset(4'b0000);
        request(2'b01, 4'h0, 8'd0);
        mode = 2'b00; tgt = 4'b0011; steps = 8'd5; tgt_valid = 1'b1;
        chk("zero_not_ready", tgt_ready, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_j", j, 0);
        chk("zero_q", q_bank, 4'b0000);
        chk("b2b_ready", tgt_ready, 1);
        tick();
        tgt_valid = 1'b0;
        chk("b2b_accepted", busy, 1);
        chk("b2b_done_pulse", done, 0);
        tick();
        chk("b2b_j", j, 4'b0011);
        tick(); tick();
        chk("b2b_done", done, 1);
        chk("b2b_q", q_bank, 4'b0011);
        tick();

        // Load equal to Q: full step with no drive
        request(2'b00, 4'b0011, 8'd0);
        tick();
        chk("same_j", j, 0);
        chk("same_k", k, 0);
        tick(); tick();
        chk("same_done", done, 1);
        chk("same_err", err, 0);
        tick();

        // Hold 1001 for two steps
        preset(4'b1001);
        request(2'b11, 4'h0, 8'd2);
        for (int i = 1; i <= 6; i++) begin
            chk("hold_j", j, 0);
            chk("hold_k", k, 0);
            chk("hold_done_early", done, 0);
            tick();
        end
        chk("hold_done", done, 1);
        chk("hold_q", q_bank, 4'b1001);
        chk("hold_err", err, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
